classificador_face: RTL and testbench

Downstream stage of the OV7670 capture datapath. After a frame has been captured, it reads the nine stored RGB565 sticker samples (3×3 quadrant RAM) one by one and classifies each into one of the six Rubik's cube colours. It delivers a packed 27-bit face vector and a one-cycle `pronto` pulse to the solver/control unit.

---
 rtl/classificador_face_pkg.sv | 29 ++
 rtl/classificador_face_if.sv | 39 +++
 rtl/classificador_pixel.sv | 50 +++++
 rtl/classificador_face.sv | 98 +++++++++
 tb/tb_classificador_face.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/classificador_face_pkg.sv
// Shared definitions for the face classifier: colour codes, FSM encoding, default thresholds.
package classificador_face_pkg;

  // 3-bit sticker colour codes; 6 is never produced
  localparam logic [2:0] BRANCO   = 3'd0;
  localparam logic [2:0] AMARELO  = 3'd1;
  localparam logic [2:0] VERMELHO = 3'd2;
  localparam logic [2:0] LARANJA  = 3'd3;
  localparam logic [2:0] VERDE    = 3'd4;
  localparam logic [2:0] AZUL     = 3'd5;
  localparam logic [2:0] INVALIDO = 3'd7;

  typedef enum logic [1:0] {
    StIdle,
    StLe,
    StClassifica,
    StFim
  } estado_t;

  // Default thresholds, all on the 6-bit channel scale
  localparam int unsigned TH_DARK_DEF  = 8;
  localparam int unsigned TH_SAT_DEF   = 12;
  localparam int unsigned TH_WHITE_DEF = 40;
  localparam int unsigned TH_HI_DEF    = 32;
  localparam int unsigned TH_YEL_DEF   = 12;

  localparam logic [26:0] CORES_RESET = 27'h7FF_FFFF;

endpackage

// File: rtl/classificador_face_if.sv
// Bus between the face classifier, the quadrant RAM and the solver/control unit.
interface classificador_face_if #(
  parameter int unsigned S_DATA = 16
);

  logic              iniciar;
  logic [S_DATA-1:0] pixel;
  logic [1:0]        addr_line;
  logic [1:0]        addr_column;
  logic [26:0]       cores;
  logic              pronto;
  logic              ocupado;
  logic              erro;

  // Control unit / RAM side
  modport master (
    output iniciar,
    output pixel,
    input  addr_line,
    input  addr_column,
    input  cores,
    input  pronto,
    input  ocupado,
    input  erro
  );

  // Classifier side
  modport slave (
    input  iniciar,
    input  pixel,
    output addr_line,
    output addr_column,
    output cores,
    output pronto,
    output ocupado,
    output erro
  );

endinterface

// File: rtl/classificador_pixel.sv
// Combinational RGB565 -> colour code classifier for a single sticker sample.
module classificador_pixel
  import classificador_face_pkg::*;
#(
  parameter int unsigned S_DATA   = 16,
  parameter int unsigned TH_DARK  = TH_DARK_DEF,
  parameter int unsigned TH_SAT   = TH_SAT_DEF,
  parameter int unsigned TH_WHITE = TH_WHITE_DEF,
  parameter int unsigned TH_HI    = TH_HI_DEF,
  parameter int unsigned TH_YEL   = TH_YEL_DEF
) (
  input  logic [S_DATA-1:0] pixel,
  output logic [2:0]        codigo
);

  // 8-bit arithmetic so G6+TH_YEL and 2*G6 never overflow
  logic [7:0] r6, g6, b6, mx, mn;

  // Channel expansion, spread, then first-match classification
  always_comb begin
    r6 = {2'b00, pixel[15:11], pixel[15]};
    g6 = {2'b00, pixel[10:5]};
    b6 = {2'b00, pixel[4:0], pixel[4]};

    mx = r6;
    if (g6 > mx) mx = g6;
    if (b6 > mx) mx = b6;
    mn = r6;
    if (g6 < mn) mn = g6;
    if (b6 < mn) mn = b6;

    codigo = INVALIDO;
    if (mx < 8'(TH_DARK)) begin
      codigo = INVALIDO;
    end else if ((mx - mn) < 8'(TH_SAT)) begin
      codigo = (mx >= 8'(TH_WHITE)) ? BRANCO : INVALIDO;
    end else if ((b6 > r6) && (b6 > g6)) begin
      codigo = AZUL;
    end else if ((r6 >= 8'(TH_HI)) && (g6 >= 8'(TH_HI)) && ((g6 + 8'(TH_YEL)) >= r6)) begin
      codigo = AMARELO;
    end else if (g6 > r6) begin
      codigo = VERDE;
    end else if ({g6[6:0], 1'b0} >= r6) begin
      codigo = LARANJA;
    end else begin
      codigo = VERMELHO;
    end
  end

endmodule

// File: rtl/classificador_face.sv
// Reads the nine stored sticker samples in raster order and builds the packed face vector.
module classificador_face
  import classificador_face_pkg::*;
#(
  parameter int unsigned S_DATA   = 16,
  parameter int unsigned TH_DARK  = TH_DARK_DEF,
  parameter int unsigned TH_SAT   = TH_SAT_DEF,
  parameter int unsigned TH_WHITE = TH_WHITE_DEF,
  parameter int unsigned TH_HI    = TH_HI_DEF,
  parameter int unsigned TH_YEL   = TH_YEL_DEF
) (
  input logic                 clock,
  input logic                 reset,
  classificador_face_if.slave bus
);

  estado_t     estado_q;
  logic [1:0]  line_q, column_q;
  logic [26:0] cores_q;
  logic        pronto_q, ocupado_q, erro_q;
  logic [2:0]  codigo;
  logic [3:0]  slot;
  logic [4:0]  base;

  classificador_pixel #(
    .S_DATA  (S_DATA),
    .TH_DARK (TH_DARK),
    .TH_SAT  (TH_SAT),
    .TH_WHITE(TH_WHITE),
    .TH_HI   (TH_HI),
    .TH_YEL  (TH_YEL)
  ) u_pixel (
    .pixel (bus.pixel),
    .codigo(codigo)
  );

  // Slot k = 3*line + column, bit offset 3*k
  assign slot = {1'b0, line_q, 1'b0} + {2'b00, line_q} + {2'b00, column_q};
  assign base = {slot, 1'b0} + {1'b0, slot};

  // Sequencer, address counter and result register; all outputs registered
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q  <= StIdle;
      line_q    <= 2'd0;
      column_q  <= 2'd0;
      cores_q   <= CORES_RESET;
      pronto_q  <= 1'b0;
      ocupado_q <= 1'b0;
      erro_q    <= 1'b0;
    end else begin
      unique case (estado_q)
        StIdle: begin
          if (bus.iniciar) begin
            estado_q  <= StLe;
            ocupado_q <= 1'b1;
            erro_q    <= 1'b0;
            line_q    <= 2'd0;
            column_q  <= 2'd0;
          end
        end
        StLe: begin
          estado_q <= StClassifica;
        end
        StClassifica: begin
          cores_q[base +: 3] <= codigo;
          erro_q             <= erro_q | (codigo == INVALIDO);
          if ((line_q == 2'd2) && (column_q == 2'd2)) begin
            estado_q <= StFim;
            pronto_q <= 1'b1;
          end else begin
            estado_q <= StLe;
            if (column_q == 2'd2) begin
              column_q <= 2'd0;
              line_q   <= line_q + 2'd1;
            end else begin
              column_q <= column_q + 2'd1;
            end
          end
        end
        StFim: begin
          estado_q  <= StIdle;
          pronto_q  <= 1'b0;
          ocupado_q <= 1'b0;
        end
        default: estado_q <= StIdle;
      endcase
    end
  end

  assign bus.addr_line   = line_q;
  assign bus.addr_column = column_q;
  assign bus.cores       = cores_q;
  assign bus.pronto      = pronto_q;
  assign bus.ocupado     = ocupado_q;
  assign bus.erro        = erro_q;

endmodule

// File: tb/tb_classificador_face.sv
// Directed bench for classificador_face with a registered-read 3x3 RAM model.
module tb_classificador_face;

  logic clock;
  logic reset;
  logic [15:0] ram [9];
  int n_total;
  int n_bad;

  classificador_face_if #(.S_DATA(16)) bus ();

  classificador_face dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Quadrant RAM: data valid one cycle after the address
  always @(posedge clock) begin
    bus.pixel <= ram[int'(bus.addr_line) * 3 + int'(bus.addr_column)];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic fill_ram(input logic [15:0] v0, input logic [15:0] v1, input logic [15:0] v2,
                          input logic [15:0] v3, input logic [15:0] v4, input logic [15:0] v5,
                          input logic [15:0] v6, input logic [15:0] v7, input logic [15:0] v8);
    ram[0] = v0; ram[1] = v1; ram[2] = v2;
    ram[3] = v3; ram[4] = v4; ram[5] = v5;
    ram[6] = v6; ram[7] = v7; ram[8] = v8;
  endtask

  // One-cycle iniciar pulse; pronto must appear on the 19th edge counting the sampling edge as 1
  task automatic run_face(input string tag, input logic [26:0] exp_cores, input logic exp_erro);
    int lat;
    @(negedge clock);
    bus.iniciar = 1'b1;
    @(negedge clock);
    bus.iniciar = 1'b0;
    lat = 1;
    check_eq({tag, "_ocupado"}, 32'(bus.ocupado), 32'd1);
    while (bus.pronto !== 1'b1 && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    check_eq({tag, "_lat"}, 32'(lat), 32'd19);
    check_eq({tag, "_cores"}, 32'(bus.cores), 32'(exp_cores));
    check_eq({tag, "_erro"}, 32'(bus.erro), 32'(exp_erro));
    @(negedge clock);
    check_eq({tag, "_pulse"}, 32'(bus.pronto), 32'd0);
    check_eq({tag, "_idle"}, 32'(bus.ocupado), 32'd0);
    @(negedge clock);
    @(negedge clock);
    check_eq({tag, "_hold"}, 32'(bus.cores), 32'(exp_cores));
  endtask

  initial begin
    int cnt;
    n_total = 0;
    n_bad   = 0;
    reset = 1'b1;
    bus.iniciar = 1'b0;
    fill_ram(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
             16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    check_eq("rst_cores", 32'(bus.cores), 32'h07FF_FFFF);
    check_eq("rst_ocupado", 32'(bus.ocupado), 32'd0);
    check_eq("rst_pronto", 32'(bus.pronto), 32'd0);
    check_eq("rst_erro", 32'(bus.erro), 32'd0);
    check_eq("rst_addr", 32'({bus.addr_line, bus.addr_column}), 32'd0);

    // All white
    run_face("white", 27'o000000000, 1'b0);

    // One of each colour: white yellow red orange green blue white yellow red
    fill_ram(16'hFFFF, 16'hFFE0, 16'hF800, 16'hFC80, 16'h07E0,
             16'h001F, 16'hFFFF, 16'hFFE0, 16'hF800);
    run_face("mixed", 27'o210543210, 1'b0);

    // Dark pixel at slot 4, grey (unsaturated, too dim for white) at slot 6
    fill_ram(16'h07E0, 16'h07E0, 16'h07E0, 16'h07E0, 16'h0000,
             16'h07E0, 16'h4208, 16'h07E0, 16'h07E0);
    run_face("invalid", 27'o447474444, 1'b1);

    // iniciar held high: back-to-back runs, period 20, erro cleared each start
    fill_ram(16'hFFFF, 16'hFFE0, 16'hF800, 16'hFC80, 16'h07E0,
             16'h001F, 16'hFFFF, 16'hFFE0, 16'hF800);
    @(negedge clock);
    bus.iniciar = 1'b1;
    cnt = 0;
    while (bus.pronto !== 1'b1 && cnt < 40) begin
      @(negedge clock);
      cnt++;
    end
    check_eq("held_first_lat", 32'(cnt), 32'd19);
    check_eq("held_first_erro", 32'(bus.erro), 32'd0);
    cnt = 0;
    do begin
      @(negedge clock);
      cnt++;
    end while (bus.pronto !== 1'b1 && cnt < 60);
    check_eq("held_period", 32'(cnt), 32'd20);
    check_eq("held_cores", 32'(bus.cores), 32'(27'o210543210));
    @(negedge clock);
    bus.iniciar = 1'b0;
    check_eq("held_pulse", 32'(bus.pronto), 32'd0);
    repeat (3) @(negedge clock);
    check_eq("held_stop", 32'(bus.ocupado), 32'd0);

    // Reset in the middle of a run
    fill_ram(16'h0000, 16'h07E0, 16'h07E0, 16'h07E0, 16'h07E0,
             16'h07E0, 16'h07E0, 16'h07E0, 16'h07E0);
    @(negedge clock);
    bus.iniciar = 1'b1;
    @(negedge clock);
    bus.iniciar = 1'b0;
    repeat (8) @(negedge clock);
    check_eq("mid_erro", 32'(bus.erro), 32'd1);
    check_eq("mid_addr", 32'({bus.addr_line, bus.addr_column}), 32'({2'd1, 2'd1}));
    reset = 1'b1;
    #1;
    check_eq("arst_cores", 32'(bus.cores), 32'h07FF_FFFF);
    check_eq("arst_ocupado", 32'(bus.ocupado), 32'd0);
    check_eq("arst_erro", 32'(bus.erro), 32'd0);
    check_eq("arst_pronto", 32'(bus.pronto), 32'd0);
    check_eq("arst_addr", 32'({bus.addr_line, bus.addr_column}), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    run_face("after_rst", 27'o444444447, 1'b1);

    // erro must clear on the next start
    fill_ram(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
             16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    run_face("clear", 27'o000000000, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
